gmm_model_mem_arbiter: RTL and testbench

//  Shares the single-port GMM model memory (per-pixel cluster set: clusters_num + cluster[2:0]) among
//  the pixel pipeline's model-fetch port, its write-back port and an HPS-triggered init sweep.

---
 rtl/gmm_model_mem_arbiter_pkg.sv | 24 ++
 rtl/gmm_model_mem_arbiter_init_sweeper.sv | 31 +++
 rtl/gmm_model_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_gmm_model_mem_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmm_model_mem_arbiter_pkg.sv
// Shared types for the GMM model memory arbiter.
// Model word layout and arbiter state encoding.
package gmm_model_mem_arbiter_pkg;

  typedef struct packed {
    logic [13:0] weight;
    logic [7:0]  mean;
    logic [15:0] variance;
  } cluster_t;

  typedef struct packed {
    logic [1:0]      clusters_num;
    cluster_t [2:0]  cluster;
  } model_t;

  localparam int MODEL_W = $bits(model_t);

  typedef enum logic [1:0] {
    ARB,
    DRAIN,
    SWEEP
  } arb_state_t;

endpackage

// File: rtl/gmm_model_mem_arbiter_init_sweeper.sv
// Init sweep address generator.
// Walks 0..NUM_WORDS-1, one step per loaded write.
module gmm_init_sweeper #(
  parameter int ADDR_W    = 21,
  parameter int NUM_WORDS = 2073600
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  // advance on each loaded sweep write; done once the last one is loaded
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      addr <= '0;
      done <= 1'b0;
    end else if (load && !done) begin
      if (addr == LAST) begin
        done <= 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gmm_model_mem_arbiter.sv
// GMM model memory arbiter: fetch, write-back and init sweep
// share one Avalon-MM port through a single command register.
module gmm_model_mem_arbiter
  import gmm_model_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 21,
  parameter int NUM_WORDS    = 2073600,
  parameter int MEM_W        = 128,
  parameter int MAX_WR_BURST = 4,
  parameter int MAX_RD_OUT   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output model_t            rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  model_t            wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_W-1:0]  mem_writedata,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [MEM_W-1:0]  mem_readdata
);

  localparam int CNT_W = $clog2(MAX_RD_OUT + 1);
  localparam int BW    = $clog2(MAX_WR_BURST + 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  rd_out;
  logic [BW-1:0]     wr_burst;
  logic              cmd_valid;
  logic              free;
  logic              rd_accept;
  logic              wr_accept;
  logic [CNT_W:0]    rd_inflight;
  logic              rd_ok;
  logic              hazard;
  logic              burst_full;
  logic              arb_open;
  logic              pick_rd;
  logic              sweep_load;
  logic              sweep_done;
  logic [ADDR_W-1:0] sweep_addr;
  logic              rd_pad_unused;

  assign cmd_valid = mem_read | mem_write;
  assign free      = !cmd_valid || !mem_waitrequest;
  assign rd_accept = mem_read && !mem_waitrequest;
  assign wr_accept = mem_write && !mem_waitrequest;

  // a read still waiting in the command stage counts against the cap
  assign rd_inflight = {1'b0, rd_out} + (CNT_W + 1)'(mem_read);
  assign rd_ok       = rd_inflight < (CNT_W + 1)'(MAX_RD_OUT);
  assign hazard      = rd_req && wr_req && (rd_addr == wr_addr);
  assign burst_full  = wr_burst >= BW'(MAX_WR_BURST);
  assign arb_open    = reset_n && (state == ARB) && !init_req && free;
  assign pick_rd     = rd_req && rd_ok &&
                       (!wr_req || (burst_full && !hazard));

  assign rd_gnt = arb_open && pick_rd;
  assign wr_gnt = arb_open && wr_req && !pick_rd;

  assign sweep_load = (state == SWEEP) && free && !sweep_done;

  assign rd_pad_unused = ^mem_readdata[MEM_W-1:MODEL_W];

  gmm_init_sweeper #(
    .ADDR_W    (ADDR_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_sweeper (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != SWEEP),
    .load    (sweep_load),
    .addr    (sweep_addr),
    .done    (sweep_done)
  );

  // command stage: load a new command whenever it is free
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else if (free) begin
      if (rd_gnt) begin
        mem_read    <= 1'b1;
        mem_write   <= 1'b0;
        mem_address <= rd_addr;
      end else if (wr_gnt) begin
        mem_read      <= 1'b0;
        mem_write     <= 1'b1;
        mem_address   <= wr_addr;
        mem_writedata <= {{(MEM_W - MODEL_W){1'b0}}, wr_data};
      end else if (sweep_load) begin
        mem_read      <= 1'b0;
        mem_write     <= 1'b1;
        mem_address   <= sweep_addr;
        mem_writedata <= '0;
      end else begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

  // outstanding read count: issued to memory but not yet returned
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_out <= '0;
    end else if (rd_accept && !mem_readdatavalid) begin
      rd_out <= rd_out + CNT_W'(1);
    end else if (!rd_accept && mem_readdatavalid && rd_out != '0) begin
      rd_out <= rd_out - CNT_W'(1);
    end
  end

  // consecutive write grants while a read is waiting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_burst <= '0;
    end else if (rd_gnt || !rd_req) begin
      wr_burst <= '0;
    end else if (wr_gnt && !burst_full) begin
      wr_burst <= wr_burst + BW'(1);
    end
  end

  // read return register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= mem_readdatavalid;
      rd_data  <= model_t'(mem_readdata[MODEL_W-1:0]);
    end
  end

  // init control: drain traffic, sweep zeros, return to arbitration
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB;
      init_busy <= 1'b0;
    end else begin
      unique case (state)
        ARB: begin
          if (init_req) begin
            state     <= DRAIN;
            init_busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (!cmd_valid && rd_out == '0) begin
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (sweep_done && wr_accept) begin
            state     <= ARB;
            init_busy <= 1'b0;
          end
        end
        default: begin
          state     <= ARB;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmm_model_mem_arbiter.sv
// Bench for gmm_model_mem_arbiter: Avalon slave model,
// reference memory, read scoreboard and directed scenarios.
module tb_gmm_model_mem_arbiter;
  import gmm_model_mem_arbiter_pkg::*;

  localparam int ADDR_W = 21;
  localparam int NW     = 16;
  localparam int MEM_W  = 128;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_req = 1'b0;
  logic              init_busy;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_gnt;
  logic              rd_valid;
  model_t            rd_data;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  model_t            wr_data = '0;
  logic              wr_gnt;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_W-1:0]  mem_writedata;
  logic              mem_waitrequest = 1'b0;
  logic              mem_readdatavalid = 1'b0;
  logic [MEM_W-1:0]  mem_readdata = '0;

  gmm_model_mem_arbiter #(
    .ADDR_W(ADDR_W), .NUM_WORDS(NW), .MEM_W(MEM_W),
    .MAX_WR_BURST(4), .MAX_RD_OUT(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .init_req(init_req), .init_busy(init_busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [MEM_W-1:0] d;
  } ret_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  model_t refmem[int];
  logic [MEM_W-1:0] slavemem[int];
  model_t exp_q[$];
  ret_t   ret_q[$];
  bit     gnt_log[$];
  int     sweep_q[$];
  int     outstanding = 0;
  int     cyc = 0;
  int     lat = 3;
  int     last_due = 0;
  int     out_at_sweep0 = -1;
  bit     wait_force = 0;
  bit     wait_rand = 0;
  bit     init_phase = 0;
  bit     prev_rdv = 0;
  bit     last_rd_gnt = 0;
  bit     last_wr_gnt = 0;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic model_t default_word(int a);
    logic [127:0] t;
    t = {32'(a) * 32'h9E3779B1, 32'(a) ^ 32'hA5A5F00F,
         32'(a) * 32'h01000193, ~32'(a)};
    return model_t'(t[MODEL_W-1:0]);
  endfunction

  function automatic model_t rnd_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return model_t'(t[MODEL_W-1:0]);
  endfunction

  function automatic model_t ref_word(int a);
    if (refmem.exists(a)) return refmem[a];
    return default_word(a);
  endfunction

  function automatic logic [MEM_W-1:0] slave_word(int a);
    if (slavemem.exists(a)) return slavemem[a];
    return {{(MEM_W - MODEL_W){1'b0}}, default_word(a)};
  endfunction

  // observer: scoreboard, reference memory and slave acceptance
  always @(negedge clk) begin
    model_t e;
    ret_t   r;
    if (reset_n) begin
      last_rd_gnt = rd_gnt;
      last_wr_gnt = wr_gnt;
      if (rd_gnt && wr_gnt) chk("dual_gnt", 1, 0);
      if (init_phase && (rd_gnt || wr_gnt))
        chk("gnt_in_init", {rd_gnt, wr_gnt}, 0);
      if (wr_gnt) begin
        refmem[int'(wr_addr)] = wr_data;
        gnt_log.push_back(1'b1);
      end
      if (rd_gnt) begin
        exp_q.push_back(ref_word(int'(rd_addr)));
        gnt_log.push_back(1'b0);
      end
      if (rd_valid || prev_rdv) chk("rd_valid_lat", rd_valid, prev_rdv);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
      prev_rdv = mem_readdatavalid;
      if (mem_write && !mem_waitrequest) begin
        chk("wr_pad", mem_writedata[MEM_W-1:MODEL_W], 0);
        slavemem[int'(mem_address)] = mem_writedata;
        if (init_phase) begin
          if (sweep_q.size() == 0) out_at_sweep0 = outstanding;
          sweep_q.push_back(int'(mem_address));
          chk("sweep_zero", mem_writedata, 0);
        end
      end
      if (mem_read && !mem_waitrequest) begin
        r.due = cyc + 1 + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        r.d = slave_word(int'(mem_address));
        r.d[MEM_W-1:MODEL_W] = 12'($urandom);
        ret_q.push_back(r);
        outstanding++;
        chk("rd_out_bound", outstanding <= 8, 1);
      end
      if (mem_readdatavalid) outstanding--;
    end
  end

  // slave driver: in-order returns and waitrequest
  always @(posedge clk) begin
    ret_t r;
    cyc++;
    #1;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      mem_readdatavalid = 1'b1;
      mem_readdata = r.d;
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_waitrequest = wait_force ||
                      (wait_rand && $urandom_range(3) == 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && k < bound) begin
      step();
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_read(logic [ADDR_W-1:0] a);
    int k;
    rd_req = 1'b1;
    rd_addr = a;
    k = 0;
    do begin
      step();
      k++;
    end while (!last_rd_gnt && k < 50);
    rd_req = 1'b0;
    if (!last_rd_gnt) chk("rd_gnt_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int nw;
    int ng;
    int k;
    int n;
    bit pulsed;
    model_t hz;
    model_t bp;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_init_busy", init_busy, 0);
    reset_n = 1'b1;

    // single read
    step();
    rd_req = 1'b1;
    rd_addr = 21'h00010;
    @(negedge clk);
    chk("ro_gnt", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    @(negedge clk);
    chk("ro_mem_read", mem_read, 1);
    chk("ro_addr", mem_address, 21'h00010);
    step();
    wait_drain(30);

    // contention: W,W,W,W,R pattern
    gnt_log.delete();
    rd_req = 1'b1;
    rd_addr = 21'h100;
    wr_req = 1'b1;
    wr_addr = 21'h200;
    wr_data = rnd_word();
    repeat (15) begin
      step();
      if (last_wr_gnt) begin
        wr_addr = wr_addr + 1'b1;
        wr_data = rnd_word();
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    chk("cont_count", gnt_log.size(), 15);
    for (int i = 0; i < 15 && i < gnt_log.size(); i++)
      chk($sformatf("cont_gnt_%0d", i), gnt_log[i], (i % 5) != 4);
    wait_drain(40);

    // hazard: same address with burst at its limit
    rd_req = 1'b1;
    rd_addr = 21'h300;
    wr_req = 1'b1;
    wr_addr = 21'h400;
    wr_data = rnd_word();
    nw = 0;
    k = 0;
    while (nw < 4 && k < 20) begin
      step();
      k++;
      if (last_rd_gnt) chk("hz_early_rd", 1, 0);
      if (last_wr_gnt) begin
        nw++;
        wr_addr = wr_addr + 1'b1;
        wr_data = rnd_word();
      end
    end
    hz = rnd_word();
    rd_addr = 21'h01234;
    wr_addr = 21'h01234;
    wr_data = hz;
    @(negedge clk);
    chk("hz_wr_first", {rd_gnt, wr_gnt}, 2'b01);
    step();
    wr_req = 1'b0;
    @(negedge clk);
    chk("hz_rd_next", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    wait_drain(40);

    // write held under waitrequest
    bp = rnd_word();
    wr_req = 1'b1;
    wr_addr = 21'h55;
    wr_data = bp;
    @(negedge clk);
    chk("bp_wr_gnt", wr_gnt, 1);
    wait_force = 1'b1;
    step();
    wr_req = 1'b0;
    rd_req = 1'b1;
    rd_addr = 21'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_mem_write", mem_write, 1);
      chk("bp_addr", mem_address, 21'h55);
      chk("bp_data", mem_writedata, {12'h0, bp});
      chk("bp_no_gnt", {rd_gnt, wr_gnt}, 0);
      if (i == 4) wait_force = 1'b0;
      step();
    end
    @(negedge clk);
    chk("bp_release_gnt", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    wait_drain(40);

    // outstanding read cap
    lat = 30;
    rd_req = 1'b1;
    rd_addr = 21'h700;
    ng = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (last_rd_gnt) begin
        ng++;
        rd_addr = rd_addr + 1'b1;
      end
    end
    chk("cap_grants", ng, 8);
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (mem_readdatavalid) break;
      chk("cap_hold", rd_gnt, 0);
      k++;
    end
    chk("cap_rdv_seen", mem_readdatavalid, 1);
    chk("cap_rdv_cycle", rd_gnt, 0);
    @(negedge clk);
    chk("cap_release", rd_gnt, 1);
    step();
    rd_req = 1'b0;
    lat = 3;
    wait_drain(150);

    // init sweep with two reads outstanding
    lat = 10;
    rd_req = 1'b1;
    rd_addr = 21'h3;
    nw = 0;
    k = 0;
    while (nw < 2 && k < 20) begin
      step();
      k++;
      if (last_rd_gnt) begin
        nw++;
        rd_addr = rd_addr + 1'b1;
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b1;
    wr_addr = 21'h20;
    wr_data = rnd_word();
    init_req = 1'b1;
    init_phase = 1'b1;
    sweep_q.delete();
    out_at_sweep0 = -1;
    for (int i = 0; i < NW; i++) refmem[i] = '0;
    @(negedge clk);
    chk("init_wins", wr_gnt, 0);
    step();
    init_req = 1'b0;
    chk("init_busy_rise", init_busy, 1);
    pulsed = 0;
    k = 0;
    while (k < 200) begin
      step();
      k++;
      init_req = 1'b0;
      n = sweep_q.size();
      chk("init_busy", init_busy, n < NW);
      if (n == 5 && !pulsed) begin
        init_req = 1'b1;
        pulsed = 1;
      end
      if (n >= NW && !init_busy) break;
    end
    init_req = 1'b0;
    init_phase = 1'b0;
    chk("sweep_count", sweep_q.size(), NW);
    for (int i = 0; i < NW && i < sweep_q.size(); i++)
      chk($sformatf("sweep_addr_%0d", i), sweep_q[i], i);
    chk("sweep_drained", out_at_sweep0, 0);
    k = 0;
    do begin
      step();
      k++;
    end while (!last_wr_gnt && k < 20);
    wr_req = 1'b0;
    chk("post_init_wr", last_wr_gnt, 1);
    lat = 3;
    do_read(21'h5);
    do_read(21'h0);
    do_read(21'hF);
    do_read(21'h20);
    wait_drain(40);

    // reset in the middle of a sweep
    init_req = 1'b1;
    init_phase = 1'b1;
    sweep_q.delete();
    step();
    init_req = 1'b0;
    k = 0;
    while (sweep_q.size() < 7 && k < 100) begin
      step();
      k++;
    end
    reset_n = 1'b0;
    wr_req = 1'b1;
    wr_addr = 21'h40;
    wr_data = rnd_word();
    step();
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_mem_read", mem_read, 0);
    chk("mid_rst_init_busy", init_busy, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_wr_gnt", wr_gnt, 0);
    exp_q.delete();
    ret_q.delete();
    outstanding = 0;
    prev_rdv = 0;
    init_phase = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_arb_gnt", wr_gnt, 1);
    step();
    wr_req = 1'b0;
    do_read(21'h40);
    wait_drain(40);

    // randomized traffic with random stalls and latency
    wait_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step();
      lat = $urandom_range(1, 6);
      if (last_rd_gnt || !rd_req) begin
        rd_req = $urandom_range(1) == 1;
        rd_addr = ADDR_W'($urandom_range(31));
      end
      if (last_wr_gnt || !wr_req) begin
        wr_req = $urandom_range(1) == 1;
        wr_addr = ADDR_W'($urandom_range(31));
        wr_data = rnd_word();
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    step();
    wait_rand = 1'b0;
    wait_drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
